// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words and writes them
// to instruction memory from address 0, then releases the CPU via start_o.
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int CNT_W       = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  input  logic             byte_last_i,
  output logic             byte_ready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic             start_o,
  output logic             busy_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] word_count_o
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);

  state_t           state_reg, state_next;
  logic [1:0]       lane_reg, lane_next;
  logic [31:0]      asm_reg, asm_next;
  logic             last_reg, last_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      data_reg, data_next;
  logic [31:0]      filled;
  logic             room;

  // Assembly word with the incoming byte dropped into the current lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign filled[8*gi +: 8] = (lane_reg == 2'(gi)) ? byte_i : asm_reg[8*gi +: 8];
    end
  endgenerate

  assign room = (count_reg < DEPTH_C);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      lane_reg  <= 2'd0;
      asm_reg   <= 32'd0;
      last_reg  <= 1'b0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      addr_reg  <= 32'd0;
      data_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      asm_reg   <= asm_next;
      last_reg  <= last_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    asm_next   = asm_reg;
    last_next  = last_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (load_i) begin
          state_next = RECV;
          lane_next  = 2'd0;
          asm_next   = 32'd0;
          last_next  = 1'b0;
          count_next = '0;
          ovf_next   = 1'b0;
        end
      end
      RECV: begin
        if (byte_valid_i) begin
          asm_next = filled;
          if (lane_reg == 2'd3 || byte_last_i) begin
            state_next = WRITE;
            last_next  = byte_last_i;
            // Address/data only move when a write will actually happen.
            if (room) begin
              addr_next = 32'({count_reg, 2'b00});
              data_next = filled;
            end
          end else begin
            lane_next = lane_reg + 2'd1;
          end
        end
      end
      WRITE: begin
        if (room) count_next = count_reg + CNT_W'(1);
        else      ovf_next   = 1'b1;
        lane_next  = 2'd0;
        asm_next   = 32'd0;
        state_next = last_reg ? DONE : RECV;
      end
      default: state_next = IDLE;
    endcase
  end

  assign byte_ready_o = (state_reg == RECV);
  assign busy_o       = (state_reg == RECV) || (state_reg == WRITE);
  assign mem_we_o     = (state_reg == WRITE) && room;
  assign start_o      = (state_reg == DONE) && !ovf_reg;
  assign mem_addr_o   = addr_reg;
  assign mem_data_o   = data_reg;
  assign overflow_o   = ovf_reg;
  assign word_count_o = count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed table-driven bench for imem_loader (DEPTH_WORDS = 4) plus hand
// sequences for async reset, load during RECV and reload from DONE.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_i, load_i, byte_valid_i, byte_last_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o, mem_we_o, start_o, busy_o, overflow_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [2:0]  word_count_o;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(4), .CNT_W(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .load_i(load_i), .byte_i(byte_i),
    .byte_valid_i(byte_valid_i), .byte_last_i(byte_last_i),
    .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .start_o(start_o), .busy_o(busy_o),
    .overflow_o(overflow_o), .word_count_o(word_count_o)
  );

  typedef struct packed {
    logic [159:0] stream;   // byte k at [8k+7:8k]
    logic [4:0]   len;
    logic         gapped;
    logic [159:0] words;    // expected write i at [32i+31:32i], address 4*i
    logic [2:0]   nwords;
    logic [2:0]   count;
    logic         ovf;
    logic         start;
  } vec_t;

  vec_t        vecs [6];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (mem_we_o) begin
      checks++;
      if (prev_we) begin
        errors++;
        $display("FAIL we_back_to_back: got we=1 twice in a row, required single-cycle pulse");
      end
      wa.push_back(mem_addr_o);
      wd.push_back(mem_data_o);
      $display("write addr=%h data=%h", mem_addr_o, mem_data_o);
    end
    prev_we <= mem_we_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic do_load();
    load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit ok;
    ok = 1'b0;
    byte_i       = b;
    byte_last_i  = last;
    byte_valid_i = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (byte_ready_o) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL byte_accept: byte %h not accepted within 20 cycles, required acceptance", b);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(busy_o), 32'd0);
    check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    check({tag, "_we"},    32'(mem_we_o), 32'd0);
    check({tag, "_start"}, 32'(start_o), 32'd0);
    check({tag, "_ovf"},   32'(overflow_o), 32'd0);
    check({tag, "_count"}, 32'(word_count_o), 32'd0);
    check({tag, "_addr"},  mem_addr_o, 32'd0);
    check({tag, "_data"},  mem_data_o, 32'd0);
  endtask

  task automatic run_row(input int r);
    vec_t v;
    v = vecs[r];
    $display("row %0d: len=%0d gapped=%0d", r, v.len, v.gapped);
    do_load();
    check("ready_after_load", 32'(byte_ready_o), 32'd1);
    for (int k = 0; k < int'(v.len); k++) begin
      if (v.gapped) begin
        byte_valid_i = 1'b0;
        byte_i       = 8'hEE;
        byte_last_i  = 1'b1;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      send_byte(v.stream[8*k +: 8], k == int'(v.len) - 1);
    end
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    // Now in the final WRITE cycle.
    check("last_write_busy",  32'(busy_o), 32'd1);
    check("last_write_start", 32'(start_o), 32'd0);
    check("last_write_we",    32'(mem_we_o), 32'(!v.ovf));
    @(posedge clk); #1;
    check("done_busy",  32'(busy_o), 32'd0);
    check("done_ready", 32'(byte_ready_o), 32'd0);
    check("done_start", 32'(start_o), 32'(v.start));
    check("done_ovf",   32'(overflow_o), 32'(v.ovf));
    check("done_count", 32'(word_count_o), 32'(v.count));
    check("num_writes", 32'(wd.size()), 32'(v.nwords));
    for (int i = 0; i < int'(v.nwords); i++) begin
      if (i < wd.size()) begin
        check("write_addr", wa[i], 32'(4 * i));
        check("write_data", wd[i], v.words[32*i +: 32]);
      end
    end
  endtask

  initial begin
    vecs[0] = '{stream: 160'h00A000B3_00000013, len: 5'd8, gapped: 1'b0,
                words: 160'h00A000B3_00000013, nwords: 3'd2, count: 3'd2, ovf: 1'b0, start: 1'b1};
    vecs[1] = '{stream: 160'h05_04030201, len: 5'd5, gapped: 1'b0,
                words: 160'h00000005_04030201, nwords: 3'd2, count: 3'd2, ovf: 1'b0, start: 1'b1};
    vecs[2] = '{stream: 160'h13121110_0F0E0D0C_0B0A0908_07060504_03020100, len: 5'd20, gapped: 1'b0,
                words: 160'h0F0E0D0C_0B0A0908_07060504_03020100, nwords: 3'd4, count: 3'd4, ovf: 1'b1, start: 1'b0};
    vecs[3] = '{stream: 160'h6655_44332211, len: 5'd6, gapped: 1'b1,
                words: 160'h00006655_44332211, nwords: 3'd2, count: 3'd2, ovf: 1'b0, start: 1'b1};
    vecs[4] = '{stream: 160'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0, len: 5'd16, gapped: 1'b1,
                words: 160'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0, nwords: 3'd4, count: 3'd4, ovf: 1'b0, start: 1'b1};
    vecs[5] = '{stream: 160'h7F, len: 5'd1, gapped: 1'b0,
                words: 160'h0000007F, nwords: 3'd1, count: 3'd1, ovf: 1'b0, start: 1'b1};

    rst_i = 1'b1; load_i = 1'b0; byte_valid_i = 1'b0; byte_last_i = 1'b0; byte_i = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Async reset after 6 bytes: outputs clear without a clock edge.
    do_load();
    for (int k = 0; k < 6; k++) send_byte(8'h11 + 8'(k), 1'b0);
    byte_valid_i = 1'b0;
    check("pre_reset_data", mem_data_o, 32'h14131211);
    #3 rst_i = 1'b1;
    #1 check_idle_outputs("async_rst");
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < 6; r++) run_row(r);

    // load_i mid-word is ignored.
    do_load();
    send_byte(8'h21, 1'b0);
    send_byte(8'h43, 1'b0);
    byte_valid_i = 1'b0;
    load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    check("recv_load_busy", 32'(busy_o), 32'd1);
    send_byte(8'h65, 1'b0);
    send_byte(8'h87, 1'b1);
    byte_valid_i = 1'b0;
    @(posedge clk); #1;
    check("recv_load_count", 32'(word_count_o), 32'd1);
    check("recv_load_start", 32'(start_o), 32'd1);
    check("recv_load_nw", 32'(wd.size()), 32'd1);
    if (wd.size() > 0) check("recv_load_data", wd[0], 32'h87654321);

    // load_i in DONE starts a fresh session.
    load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    wa.delete();
    wd.delete();
    check("reload_start", 32'(start_o), 32'd0);
    check("reload_count", 32'(word_count_o), 32'd0);
    check("reload_busy",  32'(busy_o), 32'd1);
    send_byte(8'h5A, 1'b1);
    byte_valid_i = 1'b0;
    @(posedge clk); #1;
    check("reload_done_start", 32'(start_o), 32'd1);
    check("reload_nw", 32'(wd.size()), 32'd1);
    if (wd.size() > 0) begin
      check("reload_addr", wa[0], 32'h0);
      check("reload_data", wd[0], 32'h0000005A);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
